// File: rtl/cache_set_if.sv
// Bundle between cache_set_controller and its surroundings. It carries the
// CPU request port, the broadcast/strobe lines and read-back of the four
// channel ways, the write-back handshake, and the response pulse.
//   slave  : controller view (accepts requests, drives the channel strobes)
//   master : environment view (CPU, channel ways, write-back sink)
interface cache_set_if #(
  parameter int unsigned WAYS  = 4,
  parameter int unsigned TAG_W = 8,
  parameter int unsigned IDX_W = 4,
  parameter int unsigned LRU_W = 3
);
  localparam int unsigned WAY_W = $clog2(WAYS);

  // CPU request port
  logic                   req_valid;
  logic                   req_ready;
  logic [TAG_W-1:0]       req_tag;
  logic [IDX_W-1:0]       req_index;
  logic                   req_write;
  // channel broadcast, strobes and read-back
  logic [TAG_W-1:0]       ch_tag;
  logic [IDX_W-1:0]       ch_index;
  logic                   ch_mod_in;
  logic [WAYS-1:0]        ch_wr;
  logic [WAYS-1:0]        ch_age;
  logic [WAYS*TAG_W-1:0]  ch_tag_out;
  logic [WAYS-1:0]        ch_valid;
  logic [WAYS*LRU_W-1:0]  ch_lru;
  logic [WAYS-1:0]        ch_mod_out;
  // write-back handshake
  logic                   wb_valid;
  logic                   wb_ready;
  logic [TAG_W-1:0]       wb_tag;
  logic [IDX_W-1:0]       wb_index;
  // completion
  logic                   resp_valid;
  logic                   resp_hit;
  logic [WAY_W-1:0]       resp_way;

  modport slave (
    input  req_valid, req_tag, req_index, req_write,
    input  ch_tag_out, ch_valid, ch_lru, ch_mod_out, wb_ready,
    output req_ready, ch_tag, ch_index, ch_mod_in, ch_wr, ch_age,
    output wb_valid, wb_tag, wb_index, resp_valid, resp_hit, resp_way
  );

  modport master (
    output req_valid, req_tag, req_index, req_write,
    output ch_tag_out, ch_valid, ch_lru, ch_mod_out, wb_ready,
    input  req_ready, ch_tag, ch_index, ch_mod_in, ch_wr, ch_age,
    input  wb_valid, wb_tag, wb_index, resp_valid, resp_hit, resp_way
  );
endinterface

// File: rtl/cache_set_controller.sv
// Sequencer for a 4-way set-associative tag directory. Takes one request at a
// time, looks it up across the ways, picks an LRU victim on a miss, asks for
// write-back of a dirty victim, and pulses the per-way wr/age strobes.
// Ports: clk, rst (async, active-high), bus (cache_set_if.slave: request,
// channel broadcast/strobes/read-back, write-back handshake, response).
// All outputs are registered; they are computed from the next state.
module cache_set_controller #(
  parameter int unsigned WAYS  = 4,
  parameter int unsigned TAG_W = 8,
  parameter int unsigned IDX_W = 4,
  parameter int unsigned LRU_W = 3
) (
  input logic       clk,
  input logic       rst,
  cache_set_if.slave bus
);
  localparam int unsigned WAY_W = $clog2(WAYS);

  typedef enum logic [2:0] {IDLE, LOOKUP, UPDATE, WB, FILL, RESP} state_t;

  state_t             state, state_nx;
  logic               write_q, write_nx;
  logic               hit_q, hit_nx;
  logic [WAY_W-1:0]   way_q, way_nx;
  logic [TAG_W-1:0]   tag_q, tag_nx;
  logic [IDX_W-1:0]   index_q, index_nx;
  logic               req_ready_q, req_ready_nx;
  logic               mod_in_q, mod_in_nx;
  logic [WAYS-1:0]    wr_q, wr_nx;
  logic [WAYS-1:0]    age_q, age_nx;
  logic               wb_valid_q, wb_valid_nx;
  logic [TAG_W-1:0]   wb_tag_q, wb_tag_nx;
  logic [IDX_W-1:0]   wb_index_q, wb_index_nx;
  logic               resp_valid_q, resp_valid_nx;
  logic               resp_hit_q, resp_hit_nx;
  logic [WAY_W-1:0]   resp_way_q, resp_way_nx;

  // lookup results, valid while the ways present the captured index
  logic               hit_any, hit_mod, inv_any, vic_dirty;
  logic [WAY_W-1:0]   hit_way, inv_way, max_way, victim;
  logic [LRU_W-1:0]   max_lru;
  logic [TAG_W-1:0]   vic_tag;
  logic [WAYS-1:0]    way_oh;

  // Hit detection and victim choice; scans go upward so the lowest way wins ties.
  always_comb begin
    hit_any   = 1'b0;
    hit_way   = '0;
    hit_mod   = 1'b0;
    inv_any   = 1'b0;
    inv_way   = '0;
    max_lru   = '0;
    max_way   = '0;
    vic_tag   = '0;
    vic_dirty = 1'b0;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (!hit_any && bus.ch_valid[w] && bus.ch_tag_out[w*TAG_W +: TAG_W] == tag_q) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
        hit_mod = bus.ch_mod_out[w];
      end
      if (!inv_any && !bus.ch_valid[w]) begin
        inv_any = 1'b1;
        inv_way = WAY_W'(w);
      end
      if (bus.ch_lru[w*LRU_W +: LRU_W] > max_lru) begin
        max_lru = bus.ch_lru[w*LRU_W +: LRU_W];
        max_way = WAY_W'(w);
      end
    end
    victim = inv_any ? inv_way : max_way;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (WAY_W'(w) == victim) begin
        vic_tag   = bus.ch_tag_out[w*TAG_W +: TAG_W];
        vic_dirty = bus.ch_valid[w] & bus.ch_mod_out[w];
      end
    end
  end

  // Next state, captured request, and next values of every registered output.
  always_comb begin
    state_nx      = state;
    write_nx      = write_q;
    hit_nx        = hit_q;
    way_nx        = way_q;
    tag_nx        = tag_q;
    index_nx      = index_q;
    wb_tag_nx     = wb_tag_q;
    wb_index_nx   = wb_index_q;
    req_ready_nx  = 1'b0;
    mod_in_nx     = 1'b0;
    wr_nx         = '0;
    age_nx        = '0;
    wb_valid_nx   = 1'b0;
    resp_valid_nx = 1'b0;
    resp_hit_nx   = 1'b0;
    resp_way_nx   = '0;

    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          tag_nx   = bus.req_tag;
          index_nx = bus.req_index;
          write_nx = bus.req_write;
          state_nx = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit_any) begin
          hit_nx   = 1'b1;
          way_nx   = hit_way;
          state_nx = UPDATE;
        end else begin
          hit_nx      = 1'b0;
          way_nx      = victim;
          wb_tag_nx   = vic_tag;
          wb_index_nx = index_q;
          state_nx    = vic_dirty ? WB : FILL;
        end
      end
      WB:      if (bus.wb_ready) state_nx = FILL;
      UPDATE:  state_nx = RESP;
      FILL:    state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    // the target way is written; every other valid way ages
    way_oh = WAYS'(1) << way_nx;
    case (state_nx)
      IDLE: req_ready_nx = 1'b1;
      UPDATE: begin
        wr_nx     = way_oh;
        age_nx    = bus.ch_valid & ~way_oh;
        mod_in_nx = hit_mod | write_q;
      end
      FILL: begin
        wr_nx     = way_oh;
        age_nx    = bus.ch_valid & ~way_oh;
        mod_in_nx = write_q;
      end
      WB: wb_valid_nx = 1'b1;
      RESP: begin
        resp_valid_nx = 1'b1;
        resp_hit_nx   = hit_q;
        resp_way_nx   = way_q;
      end
      default: ;
    endcase
  end

  // State and output registers; reset drops any write-back and strobe at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      write_q      <= 1'b0;
      hit_q        <= 1'b0;
      way_q        <= '0;
      tag_q        <= '0;
      index_q      <= '0;
      wb_tag_q     <= '0;
      wb_index_q   <= '0;
      req_ready_q  <= 1'b1;
      mod_in_q     <= 1'b0;
      wr_q         <= '0;
      age_q        <= '0;
      wb_valid_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_way_q   <= '0;
    end else begin
      state        <= state_nx;
      write_q      <= write_nx;
      hit_q        <= hit_nx;
      way_q        <= way_nx;
      tag_q        <= tag_nx;
      index_q      <= index_nx;
      wb_tag_q     <= wb_tag_nx;
      wb_index_q   <= wb_index_nx;
      req_ready_q  <= req_ready_nx;
      mod_in_q     <= mod_in_nx;
      wr_q         <= wr_nx;
      age_q        <= age_nx;
      wb_valid_q   <= wb_valid_nx;
      resp_valid_q <= resp_valid_nx;
      resp_hit_q   <= resp_hit_nx;
      resp_way_q   <= resp_way_nx;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.ch_tag     = tag_q;
  assign bus.ch_index   = index_q;
  assign bus.ch_mod_in  = mod_in_q;
  assign bus.ch_wr      = wr_q;
  assign bus.ch_age     = age_q;
  assign bus.wb_valid   = wb_valid_q;
  assign bus.wb_tag     = wb_tag_q;
  assign bus.wb_index   = wb_index_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_hit   = resp_hit_q;
  assign bus.resp_way   = resp_way_q;
endmodule
